// File: rtl/lc4_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc4_div_pkg
// Purpose  : Shared constants and FSM state type for the LC4 iterative
//            divider.
// Revision : 1.0 - initial release
// ============================================================================
package lc4_div_pkg;

  // Operand width; the trial subtractor is a fixed 16-bit adder.
  localparam int W     = 16;
  // Iteration counter width; must hold the value W.
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : lc4_div_pkg
`default_nettype wire

// File: rtl/cla16.sv
`default_nettype none
// ============================================================================
// Module   : cla16
// Purpose  : 16-bit carry-lookahead adder (4 groups of 4 bits, group-level
//            lookahead). No carry out; callers rebuild it from bit 15.
// Revision : 1.0 - initial release
// ============================================================================
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  cg;   // carry into each 4-bit group
  logic [2:0]  gg;   // group generate (top group not needed)
  logic [2:0]  gp;   // group propagate (top group not needed)

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // Group generate/propagate for the three groups feeding a lookahead carry.
  for (genvar j = 0; j < 3; j++) begin : g_lk
    assign gp[j] = &p[4*j +: 4];
    assign gg[j] = g[4*j+3]
                 | (p[4*j+3] & g[4*j+2])
                 | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
  end

  // Flattened lookahead across groups.
  assign cg[0] = cin_i;
  assign cg[1] = gg[0] | (gp[0] & cin_i);
  assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
  assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin_i);

  // Per-bit lookahead carries inside each group.
  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign c[4*j]   = cg[j];
    assign c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
    assign c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                    | (p[4*j+1] & p[4*j] & cg[j]);
    assign c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                    | (p[4*j+2] & p[4*j+1] & g[4*j])
                    | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
  end

  assign sum_o = p ^ c;

endmodule : cla16
`default_nettype wire

// File: rtl/lc4_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : lc4_div_iter
// Purpose  : Multi-cycle unsigned 16-bit restoring divider (DIV/MOD) for the
//            LC4 ALU. One quotient bit per cycle; the trial subtraction is a
//            single cla16 computing s + ~d + 1.
// Revision : 1.0 - initial release
// ============================================================================
module lc4_div_iter #(
  parameter int W     = lc4_div_pkg::W,     // only 16 is legal (cla16 width)
  parameter int CNT_W = lc4_div_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);

  import lc4_div_pkg::*;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     q_q;      // working quotient / remaining dividend bits
  logic [W-1:0]     r_q;      // working partial remainder
  logic [W-1:0]     d_q;      // latched divisor
  logic [W-1:0]     quot_q;
  logic [W-1:0]     rem_q;

  logic             accept;
  logic             div_zero;
  logic             last;
  logic [W-1:0]     s;
  logic [W-1:0]     nd;
  logic [W-1:0]     t;
  logic             top;
  logic             c15;
  logic             cout;
  logic             ge;
  logic [W-1:0]     r_next;
  logic [W-1:0]     q_next;

  assign o_ready  = (state_q != DIV_RUN);
  assign o_valid  = (state_q == DIV_DONE);
  assign accept   = i_start & o_ready;
  assign div_zero = (i_divisor == '0);
  assign last     = (cnt_q == CNT_W'(W - 1));

  // Shift the next dividend bit into the partial remainder; the bit shifted
  // out of r widens the comparison to 17 bits.
  assign s   = {r_q[W-2:0], q_q[W-1]};
  assign top = r_q[W-1];
  assign nd  = ~d_q;

  cla16 u_sub (
    .a_i   (s),
    .b_i   (nd),
    .cin_i (1'b1),
    .sum_o (t)
  );

  // Recover the adder's carry out from its MSB sum bit.
  assign c15  = t[W-1] ^ s[W-1] ^ nd[W-1];
  assign cout = (s[W-1] & nd[W-1]) | (s[W-1] & c15) | (nd[W-1] & c15);
  assign ge   = top | cout;

  assign r_next = ge ? t : s;
  assign q_next = {q_q[W-2:0], ge};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE behaves like IDLE for a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (accept) begin
          state_d = div_zero ? DIV_DONE : DIV_RUN;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (last) begin
          state_d = DIV_DONE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Working datapath: load on accept, one restoring step per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      q_q   <= i_dividend;
      r_q   <= '0;
      d_q   <= i_divisor;
      cnt_q <= '0;
    end else if (state_q == DIV_RUN) begin
      q_q   <= q_next;
      r_q   <= r_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Result registers change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if (accept && div_zero) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if ((state_q == DIV_RUN) && last) begin
      quot_q <= q_next;
      rem_q  <= r_next;
    end
  end

  assign o_quotient  = quot_q;
  assign o_remainder = rem_q;

endmodule : lc4_div_iter
`default_nettype wire

// File: tb/tb_lc4_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc4_div_iter
// Purpose  : Self-checking bench for lc4_div_iter: directed vector table,
//            multi-cycle corner sequences and a random-operand run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc4_div_iter;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_quotient;
  logic [15:0] o_remainder;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [15:0] dd;
    logic [15:0] dv;
    logic [15:0] eq;
    logic [15:0] er;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[12];

  lc4_div_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp_v);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp_v);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Wait (bounded) for o_valid; returns cycles counted from the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Starts and ends on a negedge. Operands are scrambled after accept.
  task automatic run_op(input logic [15:0] dd, input logic [15:0] dv,
                        input logic [15:0] eq, input logic [15:0] er,
                        input int elat, input string nm);
    int lat;
    chk1({nm, "_ready"}, o_ready, 1'b1);
    i_start    = 1'b1;
    i_dividend = dd;
    i_divisor  = dv;
    @(negedge clk);
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
    wait_valid(lat);
    chkint({nm, "_latency"}, lat, elat);
    chk16({nm, "_quot"}, o_quotient, eq);
    chk16({nm, "_rem"}, o_remainder, er);
    @(negedge clk);
    chk1({nm, "_pulse_end"}, o_valid, 1'b0);
  endtask

  // o_valid must never be high on two consecutive cycles in these tests.
  logic prev_valid;
  always @(negedge clk) begin
    if (o_valid) begin
      n_cmp++;
      if (prev_valid) begin
        n_err++;
        $display("FAIL valid_pulse: got 2-cycle o_valid expected 1-cycle pulse");
      end
    end
    prev_valid = o_valid;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          seen;
    logic [15:0] rdd;
    logic [15:0] rdv;
    logic [15:0] rq;
    logic [15:0] rr;

    n_cmp      = 0;
    n_err      = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      17, "v100_7"};
    vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'h0000,   17, "vffff_1"};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,   16'h0001,   16'h0000,   17, "vffff_ffff"};
    vecs[3]  = '{16'h8000,  16'hC000,   16'h0000,   16'h8000,   17, "v8000_c000"};
    vecs[4]  = '{16'h1234,  16'h0000,   16'h0000,   16'h0000,   1,  "vdiv0"};
    vecs[5]  = '{16'd50,    16'd5,      16'd10,     16'd0,      17, "v50_5"};
    vecs[6]  = '{16'd5,     16'd9,      16'd0,      16'd5,      17, "v5_9"};
    vecs[7]  = '{16'd0,     16'd5,      16'd0,      16'd0,      17, "v0_5"};
    vecs[8]  = '{16'hFFFF,  16'h8001,   16'h0001,   16'h7FFE,   17, "vffff_8001"};
    vecs[9]  = '{16'hFFFE,  16'h7FFF,   16'h0002,   16'h0000,   17, "vfffe_7fff"};
    vecs[10] = '{16'd65535, 16'd10,     16'd6553,   16'd5,      17, "v65535_10"};
    vecs[11] = '{16'd1000,  16'd33,     16'd30,     16'd10,     17, "v1000_33"};

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_valid", o_valid, 1'b0);
    chk16("rst_quot", o_quotient, 16'h0000);
    chk16("rst_rem", o_remainder, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].eq, vecs[i].er, vecs[i].lat, vecs[i].nm);
    end

    // i_start held through RUN with changing operands is ignored
    i_start    = 1'b1;
    i_dividend = 16'd100;
    i_divisor  = 16'd7;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      chk1("held_ready_low", o_ready, 1'b0);
      i_dividend = 16'($urandom);
      i_divisor  = 16'($urandom) | 16'h0001;
      if (k == 16) i_start = 1'b0;
      @(negedge clk);
    end
    chk1("held_valid", o_valid, 1'b1);
    chk16("held_quot", o_quotient, 16'd14);
    chk16("held_rem", o_remainder, 16'd2);
    @(negedge clk);
    chk1("held_pulse_end", o_valid, 1'b0);

    // Asynchronous reset in RUN cycle 8 aborts the op
    i_start    = 1'b1;
    i_dividend = 16'd100;
    i_divisor  = 16'd7;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk16("arst_quot", o_quotient, 16'h0000);
    chk16("arst_rem", o_remainder, 16'h0000);
    chk1("arst_ready", o_ready, 1'b1);
    chk1("arst_valid", o_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chkint("arst_no_valid", seen, 0);
    run_op(16'd50, 16'd5, 16'd10, 16'd0, 17, "after_rst");

    // Back-to-back: new op accepted in the DONE cycle
    i_start    = 1'b1;
    i_dividend = 16'd9;
    i_divisor  = 16'd2;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid(lat);
    chkint("b2b_first_latency", lat, 17);
    chk16("b2b_first_quot", o_quotient, 16'd4);
    chk16("b2b_first_rem", o_remainder, 16'd1);
    chk1("b2b_done_ready", o_ready, 1'b1);
    i_start    = 1'b1;
    i_dividend = 16'd1000;
    i_divisor  = 16'd33;
    @(negedge clk);
    i_start = 1'b0;
    chk1("b2b_run_ready", o_ready, 1'b0);
    chk1("b2b_run_valid", o_valid, 1'b0);
    chk16("b2b_hold_quot", o_quotient, 16'd4);
    chk16("b2b_hold_rem", o_remainder, 16'd1);
    wait_valid(lat);
    chkint("b2b_second_latency", lat, 17);
    chk16("b2b_second_quot", o_quotient, 16'd30);
    chk16("b2b_second_rem", o_remainder, 16'd10);
    @(negedge clk);

    // Random operands against the language / and % operators
    for (int n = 0; n < 2000; n++) begin
      rdd = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rdv = 16'($urandom_range(0, 255));
        1:       rdv = 16'($urandom_range(0, 15));
        default: rdv = 16'($urandom);
      endcase
      if (rdv == 16'd0) begin
        rq = 16'd0;
        rr = 16'd0;
      end else begin
        rq = rdd / rdv;
        rr = rdd % rdv;
      end
      run_op(rdd, rdv, rq, rr, (rdv == 16'd0) ? 1 : 17, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule : tb_lc4_div_iter
`default_nettype wire
